rvvi_trace_emitter: RTL
=======================

# rvvi_trace_emitter

Producer end of the RVVI trace interface: accepts one retirement event per cycle from the core's writeback stage, buffers it in a small FIFO, stamps a gap-free 64-bit order number, and presents the event in RVVI form. The RVVI form carries a shadowed X register file with a one-hot writeback mask, and optionally a single CSR write. It sits between the hart and the trace consumers: coverage collection, a lockstep comparator, or a file writer. Single hart, one retire slot per event.

## Interface
- XLEN, 32, GPR and PC width (32 or 64)
- ILEN, 32, instruction width
- NUM_REGS, 32, architectural X registers (16 for RV32E)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  interface clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  retirement event offered
- in_ready  out  1  emitter can accept event
- in_insn  in  ILEN  instruction bits
- in_pc  in  XLEN  PC of instruction
- in_pc_next  in  XLEN  PC of next instruction
- in_trap  in  1  event is a trap (no retirement)
- in_mode  in  2  privilege mode
- in_rd  in  5  destination register index
- in_rd_we  in  1  destination written
- in_rd_data  in  XLEN  value written
- in_csr_we / in_csr_addr / in_csr_data  in  1/12/XLEN  CSR write (macro only)
- valid  out  1  trace event presented
- trace_ready  in  1  consumer accepts event
- order  out  64  event order number
- insn, pc_rdata, pc_wdata, trap, mode  out  as inputs  head event fields
- x_wdata  out  NUM_REGS×XLEN  X register file after this event
- x_wb  out  NUM_REGS  one-hot writeback flag
- csr_wb / csr_addr / csr_wdata  out  1/12/XLEN  CSR write (macro only)
- rd_err  out  1  sticky: write to index ≥ NUM_REGS seen

## Operation
- Push on in_valid&&in_ready; pop on valid&&trace_ready.
- in_ready = (count < DEPTH). It does not look at trace_ready, so a full FIFO never takes a same-cycle push and pop.
- valid = (count ≠ 0). All head fields are taken from the FIFO head entry.
- order counter: resets to 0 and increments by 1 on every pop. No gaps, no reuse. Wraps modulo 2^64.
- Shadow register file X[NUM_REGS]:
  - Resets to all zero.
  - On pop, if the head entry has rd_we, rd≠0 and rd<NUM_REGS, X[rd] ← rd_data.
- x_wdata[i] = (head applies a write to i) ? head rd_data : X[i]. So the presented event already includes its own write.
- x_wb has bit rd set only when the write applies. Otherwise, including rd=0 and trap events, x_wb=0.
- Traps still carry rd_we; the emitter honours it unchanged. The core is responsible for deasserting it.
- rd ≥ NUM_REGS with rd_we: the write is dropped and x_wb=0. rd_err is set when the entry is pushed. rd_err is cleared only by reset.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

## Timing
- Reset (reset_n low at a clk edge), outputs on the following cycle:
  - count=0, valid=0, in_ready=1, order=0, X all zero, rd_err=0.
  - x_wb=0, csr_wb=0.
  - Head payload outputs are don't-care while valid=0.
- Reset in mid-operation discards all buffered events. The order counter and shadow registers restart from zero.
- Latency: an event pushed at edge N is presented with valid=1 after edge N; push-to-valid latency is one cycle. There is no combinational in→out path.
- While valid && !trace_ready, every output is held stable.
- Pop and push in the same cycle (count<DEPTH): count is unchanged and the FIFO advances.
- Back-to-back pops: at most one event per cycle; order goes up by 1 each cycle.

## Configuration
- RVVI_EMIT_CSR_EN defined:
  - The in_csr_* inputs and csr_* outputs exist.
  - The CSR write is buffered with its event and presented alongside it.
  - csr_wb = head csr_we.
- RVVI_EMIT_CSR_EN undefined:
  - The ports and the FIFO storage for them are absent.
  - Consumers see no CSR writebacks.

## Test plan
- Reset, then push 3 events (rd=5/6/0, data 0x11/0x22/0x33), trace_ready=1. Required: valid events with order 0,1,2; x_wb 0x20, 0x40, 0; final x_wdata[5]=0x11, x_wdata[6]=0x22, x_wdata[0]=0.
- trace_ready=0 while pushing DEPTH+1 events. Required: in_ready drops after DEPTH pushes and head outputs stay constant. Then raise trace_ready and require DEPTH pops in DEPTH cycles with consecutive order values.
- FIFO full with push and trace_ready both high. Required: no push that cycle and count becomes DEPTH-1. Next cycle in_ready=1.
- NUM_REGS=16, push rd=17 with rd_we. Required: x_wb=0, x_wdata unchanged, rd_err=1 until reset.
- Reset asserted with 2 events queued. Required: valid=0 the next cycle; the next pushed event is presented with order=0 and x_wdata all zero apart from its own write.
- With RVVI_EMIT_CSR_EN defined, push an event with a CSR write to 0x300, data 0x8. Required: it is presented with csr_wb=1, csr_addr=0x300, csr_wdata=0x8. The following event without a CSR write shows csr_wb=0.

Source files
------------

// File: rtl/rvvi_trace_emitter.sv
// rvvi_trace_emitter
// Producer end of an RVVI trace port for a single hart. Retirement events
// from writeback are queued in a DEPTH-entry FIFO, stamped with a gap-free
// 64-bit order number on pop, and presented with a shadow X register file
// that already includes the head event's own register write.
//
// Optional feature macro: RVVI_EMIT_CSR_EN
//   defined   -> in_csr_* / csr_* ports exist and one CSR write per event is
//                carried through the FIFO
//   undefined -> no CSR ports or storage
//
// Handshake: a transfer happens on a clk edge where valid and ready are both
// high (in_valid/in_ready upstream, valid/trace_ready downstream). A source
// keeps its payload stable while valid is high and ready is low. in_ready
// depends only on FIFO occupancy, never on trace_ready.
module rvvi_trace_emitter #(
  parameter int XLEN     = 32,
  parameter int ILEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  // writeback side
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ILEN-1:0]          in_insn,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pc_next,
  input  logic                     in_trap,
  input  logic [1:0]               in_mode,
  input  logic [4:0]               in_rd,
  input  logic                     in_rd_we,
  input  logic [XLEN-1:0]          in_rd_data,
`ifdef RVVI_EMIT_CSR_EN
  input  logic                     in_csr_we,
  input  logic [11:0]              in_csr_addr,
  input  logic [XLEN-1:0]          in_csr_data,
`endif
  // trace side
  output logic                     valid,
  input  logic                     trace_ready,
  output logic [63:0]              order,
  output logic [ILEN-1:0]          insn,
  output logic [XLEN-1:0]          pc_rdata,
  output logic [XLEN-1:0]          pc_wdata,
  output logic                     trap,
  output logic [1:0]               mode,
  output logic [NUM_REGS*XLEN-1:0] x_wdata,
  output logic [NUM_REGS-1:0]      x_wb,
`ifdef RVVI_EMIT_CSR_EN
  output logic                     csr_wb,
  output logic [11:0]              csr_addr,
  output logic [XLEN-1:0]          csr_wdata,
`endif
  output logic                     rd_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage, one array per field
  logic [ILEN-1:0] mem_insn    [DEPTH];
  logic [XLEN-1:0] mem_pc      [DEPTH];
  logic [XLEN-1:0] mem_pc_next [DEPTH];
  logic            mem_trap    [DEPTH];
  logic [1:0]      mem_mode    [DEPTH];
  logic [4:0]      mem_rd      [DEPTH];
  logic            mem_rd_we   [DEPTH];
  logic [XLEN-1:0] mem_rd_data [DEPTH];
`ifdef RVVI_EMIT_CSR_EN
  logic            mem_csr_we   [DEPTH];
  logic [11:0]     mem_csr_addr [DEPTH];
  logic [XLEN-1:0] mem_csr_data [DEPTH];
`endif

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [63:0]     order_q;
  logic            rd_err_q;
  logic [XLEN-1:0] x_q [NUM_REGS];

  logic            push;
  logic            pop;
  logic [4:0]      head_rd;
  logic            head_rd_we;
  logic [XLEN-1:0] head_rd_data;
  logic            head_apply;
  logic            in_rd_bad;

  assign in_ready = (count < CW'(DEPTH));
  assign valid    = (count != '0);
  assign push     = in_valid && in_ready;
  assign pop      = valid && trace_ready;

  assign head_rd      = mem_rd[rd_ptr];
  assign head_rd_we   = mem_rd_we[rd_ptr];
  assign head_rd_data = mem_rd_data[rd_ptr];

  // A head write lands in the shadow file only for a real, in-range, non-x0 target
  assign head_apply = valid && head_rd_we && (head_rd != 5'd0) &&
                      ({1'b0, head_rd} < 6'(NUM_REGS));
  assign in_rd_bad  = in_rd_we && ({1'b0, in_rd} >= 6'(NUM_REGS));

  // Write the accepted event into the tail slot (payload needs no reset)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_insn[wr_ptr]    <= in_insn;
      mem_pc[wr_ptr]      <= in_pc;
      mem_pc_next[wr_ptr] <= in_pc_next;
      mem_trap[wr_ptr]    <= in_trap;
      mem_mode[wr_ptr]    <= in_mode;
      mem_rd[wr_ptr]      <= in_rd;
      mem_rd_we[wr_ptr]   <= in_rd_we;
      mem_rd_data[wr_ptr] <= in_rd_data;
`ifdef RVVI_EMIT_CSR_EN
      mem_csr_we[wr_ptr]   <= in_csr_we;
      mem_csr_addr[wr_ptr] <= in_csr_addr;
      mem_csr_data[wr_ptr] <= in_csr_data;
`endif
    end
  end

  // Pointers, occupancy, order number and sticky error flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      order_q  <= '0;
      rd_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        order_q <= order_q + 64'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && in_rd_bad) rd_err_q <= 1'b1;
    end
  end

  // Shadow X register file: commit the head write when the event is consumed
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) x_q[i] <= '0;
    end else if (pop && head_apply) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (head_rd == 5'(i)) x_q[i] <= head_rd_data;
      end
    end
  end

  // Presented register file merges the head's own write over the shadow copy
  always_comb begin
    x_wb    = '0;
    x_wdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      x_wb[i] = head_apply && (head_rd == 5'(i));
      x_wdata[i*XLEN +: XLEN] = (head_apply && (head_rd == 5'(i))) ?
                                head_rd_data : x_q[i];
    end
  end

  assign order    = order_q;
  assign rd_err   = rd_err_q;
  assign insn     = mem_insn[rd_ptr];
  assign pc_rdata = mem_pc[rd_ptr];
  assign pc_wdata = mem_pc_next[rd_ptr];
  assign trap     = mem_trap[rd_ptr];
  assign mode     = mem_mode[rd_ptr];

`ifdef RVVI_EMIT_CSR_EN
  assign csr_wb    = valid && mem_csr_we[rd_ptr];
  assign csr_addr  = mem_csr_addr[rd_ptr];
  assign csr_wdata = mem_csr_data[rd_ptr];
`endif

endmodule
